// File: rtl/rot_sweep_seq.sv
// rot_sweep_seq: drives a combinational rotator through a sweep of shift
// amounts for one base word and streams each (amount, result) pair out
// over a valid/ready port.
// Optional build macro ROT_SWEEP_CHECK_EN: adds an internal rotate model
// that raises a sticky err flag when the rotator disagrees with it.
//
// state | meaning
// IDLE  | waiting for start; done pulses here after a finished sweep
// DRIVE | rotator inputs valid; result captured at the end of this cycle
// OUT   | result presented, waiting for res_ready
module rot_sweep_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_data,
  input  logic [SHW-1:0]   amt_first,
  input  logic [SHW-1:0]   amt_last,
  input  logic [SHW-1:0]   amt_step,
  input  logic             dir,
  output logic             busy,
  output logic [WIDTH-1:0] rot_data_in,
  output logic [SHW-1:0]   rot_shift_amount,
  output logic             rot_direction,
  input  logic [WIDTH-1:0] rot_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [SHW-1:0]   res_amount,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_OUT} state_t;

  localparam logic [SHW:0] CNT_MAX = (SHW+1)'(WIDTH);

  state_t       state, state_nxt;
  logic [SHW-1:0] last_q, step_q;
  logic [SHW:0]   cnt;
  logic           accept, hs, is_last;

  // The rotator input registers double as the sweep state: rot_data_in is the
  // captured base, rot_direction the captured direction, and rot_shift_amount
  // the current amount. This keeps rot_* stable outside DRIVE for free.

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hs        = 1'b0;
    busy      = (state != S_IDLE);
    is_last   = (res_amount == last_q) || (step_q == '0) || (cnt == CNT_MAX);
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: state_nxt = S_OUT;
      S_OUT: begin
        if (res_valid && res_ready) begin
          hs        = 1'b1;
          state_nxt = is_last ? S_IDLE : S_DRIVE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sweep configuration, rotator drive, result capture and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_data_in      <= '0;
      rot_shift_amount <= '0;
      rot_direction    <= 1'b0;
      last_q           <= '0;
      step_q           <= '0;
      cnt              <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      res_amount       <= '0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        rot_data_in      <= base_data;
        rot_shift_amount <= amt_first;
        rot_direction    <= dir;
        last_q           <= amt_last;
        step_q           <= amt_step;
        cnt              <= '0;
      end
      if (state == S_DRIVE) begin
        res_data   <= rot_data_out;
        res_amount <= rot_shift_amount;
        res_valid  <= 1'b1;
        cnt        <= cnt + 1'b1;
      end
      if (hs) begin
        res_valid <= 1'b0;
        if (is_last) done <= 1'b1;
        else         rot_shift_amount <= rot_shift_amount + step_q;
      end
    end
  end

`ifdef ROT_SWEEP_CHECK_EN
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   model_word;

  // Reference rotate: shifting a doubled word exposes the rotated value.
  always_comb begin
    dbl        = '0;
    model_word = '0;
    if (rot_direction) begin
      dbl        = {rot_data_in, rot_data_in} << rot_shift_amount;
      model_word = dbl[2*WIDTH-1:WIDTH];
    end else begin
      dbl        = {rot_data_in, rot_data_in} >> rot_shift_amount;
      model_word = dbl[WIDTH-1:0];
    end
  end

  // Sticky mismatch flag, compared on the same edge that captures the result.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((state == S_DRIVE) && (rot_data_out != model_word)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
